// File: rtl/lsb_gen2.sv
`default_nettype none
// ============================================================================
// Module   : lsb_gen2
// Purpose  : Second-generation load-store buffer. Keeps memory ops in program
//            order, wakes pending operands from the RS broadcast and its own
//            load-result broadcast, and issues one access at a time to memory.
//            A DRAIN state lets a flush land safely while an access is in
//            flight.
// Ports    : clk_in/rst_in (async active-low) ; rdy_in global stall
//            rob_clear/rob_head_id  : flush and commit-head tag from ROB
//            dc_*                   : insert port from decoder
//            lsb_full               : registered full flag
//            mem_*                  : single outstanding memory access
//            rs_valid/rs_tag/rs_val : RS result broadcast
//            out_valid/out_tag/out_val : own result broadcast
// Revision : 1.0 - initial release
// ============================================================================
module lsb_gen2 #(
  parameter int          DEPTH       = 16,
  parameter int          ROB_W       = 4,
  parameter int          FULL_MARGIN = 1,
  parameter logic [31:0] IO_BASE     = 32'h30000,
  parameter logic [31:0] IO_LAST     = 32'h30007
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_clear,
  input  logic [ROB_W-1:0] rob_head_id,
  input  logic             dc_valid,
  input  logic [9:0]       dc_op,
  input  logic [31:0]      dc_imm,
  input  logic             dc_rdy1,
  input  logic             dc_rdy2,
  input  logic [ROB_W-1:0] dc_q1,
  input  logic [ROB_W-1:0] dc_q2,
  input  logic [31:0]      dc_v1,
  input  logic [31:0]      dc_v2,
  input  logic [ROB_W-1:0] dc_dest,
  output logic             lsb_full,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [2:0]       mem_funct3,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_stuck,
  input  logic             rs_valid,
  input  logic [ROB_W-1:0] rs_tag,
  input  logic [31:0]      rs_val,
  output logic             out_valid,
  output logic [ROB_W-1:0] out_tag,
  output logic [31:0]      out_val
);

  localparam int             PW        = $clog2(DEPTH);
  localparam int             CW        = PW + 1;
  localparam logic [CW-1:0]  CNT_MAX   = CW'(DEPTH);
  localparam logic [CW-1:0]  FULL_TH   = CW'(DEPTH - FULL_MARGIN);
  localparam logic [6:0]     OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2} state_t;

  state_t state, state_next;

  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count, count_next;

  logic             valid [DEPTH];
  logic [9:0]       op    [DEPTH];
  logic [31:0]      imm   [DEPTH];
  logic             rdy1  [DEPTH];
  logic             rdy2  [DEPTH];
  logic [ROB_W-1:0] q1    [DEPTH];
  logic [ROB_W-1:0] q2    [DEPTH];
  logic [31:0]      v1    [DEPTH];
  logic [31:0]      v2    [DEPTH];
  logic [ROB_W-1:0] dest  [DEPTH];

  logic        head_store, head_mmio, issue, pop, ins;
  logic [31:0] head_addr;
  logic        in_rdy1, in_rdy2;
  logic [31:0] in_v1, in_v2;

  always_comb begin
    head_addr  = v1[head] + imm[head];
    head_store = (op[head][6:0] == OPC_STORE);
    head_mmio  = (head_addr >= IO_BASE) && (head_addr <= IO_LAST);
    // Stores and MMIO loads have side effects, so they wait for the ROB head.
    issue = (state == IDLE) && !rob_clear && (count != '0) && !mem_stuck &&
            rdy1[head] && rdy2[head] &&
            ((!head_store && !head_mmio) || (dest[head] == rob_head_id));
    // A DRAIN completion belongs to a flushed op: no pop, no broadcast.
    pop       = (state == BUSY) && mem_done;
    out_valid = pop;
    out_tag   = dest[head];
    out_val   = mem_rdata;
    ins       = dc_valid && !rob_clear && (count != CNT_MAX);
    count_next = rob_clear ? '0 : (count + CW'(ins) - CW'(pop));

    // Incoming operands can be satisfied by a same-cycle broadcast.
    in_rdy1 = dc_rdy1 || (out_valid && out_tag == dc_q1) || (rs_valid && rs_tag == dc_q1);
    in_rdy2 = dc_rdy2 || (out_valid && out_tag == dc_q2) || (rs_valid && rs_tag == dc_q2);
    in_v1   = dc_rdy1 ? dc_v1 : ((out_valid && out_tag == dc_q1) ? out_val : rs_val);
    in_v2   = dc_rdy2 ? dc_v2 : ((out_valid && out_tag == dc_q2) ? out_val : rs_val);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = BUSY;
      BUSY: begin
        if (mem_done)       state_next = IDLE;
        else if (rob_clear) state_next = DRAIN;
      end
      DRAIN:   if (mem_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      lsb_full   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid[i] <= 1'b0;
        op[i]    <= '0;
        imm[i]   <= '0;
        rdy1[i]  <= 1'b1;
        rdy2[i]  <= 1'b1;
        q1[i]    <= '0;
        q2[i]    <= '0;
        v1[i]    <= '0;
        v2[i]    <= '0;
        dest[i]  <= '0;
      end
    end else if (rdy_in) begin
      state    <= state_next;
      count    <= count_next;
      lsb_full <= (count_next >= FULL_TH);

      if (issue) begin
        mem_req    <= 1'b1;
        mem_we     <= head_store;
        mem_addr   <= head_addr;
        mem_wdata  <= v2[head];
        mem_funct3 <= op[head][9:7];
      end else if ((state == BUSY || state == DRAIN) && mem_done) begin
        mem_req <= 1'b0;
      end

      if (rob_clear) begin
        head <= '0;
        tail <= '0;
        for (int i = 0; i < DEPTH; i++) valid[i] <= 1'b0;
      end else begin
        // Wakeup: rs_val takes priority over out_val when both match.
        for (int i = 0; i < DEPTH; i++) begin
          if (valid[i] && !(ins && PW'(i) == tail)) begin
            if (!rdy1[i]) begin
              if (rs_valid && rs_tag == q1[i]) begin
                rdy1[i] <= 1'b1;
                v1[i]   <= rs_val;
              end else if (out_valid && out_tag == q1[i]) begin
                rdy1[i] <= 1'b1;
                v1[i]   <= out_val;
              end
            end
            if (!rdy2[i]) begin
              if (rs_valid && rs_tag == q2[i]) begin
                rdy2[i] <= 1'b1;
                v2[i]   <= rs_val;
              end else if (out_valid && out_tag == q2[i]) begin
                rdy2[i] <= 1'b1;
                v2[i]   <= out_val;
              end
            end
          end
        end
        if (pop) begin
          valid[head] <= 1'b0;
          head        <= head + PW'(1);
        end
        if (ins) begin
          valid[tail] <= 1'b1;
          op[tail]    <= dc_op;
          imm[tail]   <= dc_imm;
          rdy1[tail]  <= in_rdy1;
          rdy2[tail]  <= in_rdy2;
          q1[tail]    <= dc_q1;
          q2[tail]    <= dc_q2;
          v1[tail]    <= in_v1;
          v2[tail]    <= in_v2;
          dest[tail]  <= dc_dest;
          tail        <= tail + PW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsb_gen2.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsb_gen2
// Purpose  : Directed self-checking bench for lsb_gen2 (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsb_gen2;

  localparam logic [9:0] LW = {3'b010, 7'b0000011};
  localparam logic [9:0] SW = {3'b010, 7'b0100011};

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear;
  logic [3:0]  rob_head_id;
  logic        dc_valid, dc_rdy1, dc_rdy2;
  logic [9:0]  dc_op;
  logic [31:0] dc_imm, dc_v1, dc_v2;
  logic [3:0]  dc_q1, dc_q2, dc_dest;
  logic        lsb_full, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_done, mem_stuck;
  logic [31:0] mem_rdata;
  logic        rs_valid;
  logic [3:0]  rs_tag;
  logic [31:0] rs_val;
  logic        out_valid;
  logic [3:0]  out_tag;
  logic [31:0] out_val;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  lsb_gen2 dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .rob_head_id(rob_head_id), .dc_valid(dc_valid), .dc_op(dc_op),
    .dc_imm(dc_imm), .dc_rdy1(dc_rdy1), .dc_rdy2(dc_rdy2), .dc_q1(dc_q1),
    .dc_q2(dc_q2), .dc_v1(dc_v1), .dc_v2(dc_v2), .dc_dest(dc_dest),
    .lsb_full(lsb_full), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_stuck(mem_stuck),
    .rs_valid(rs_valid), .rs_tag(rs_tag), .rs_val(rs_val),
    .out_valid(out_valid), .out_tag(out_tag), .out_val(out_val)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Present one decoder insert for a single clock edge.
  task automatic put(input logic [9:0] op, input logic [31:0] v1, input logic [31:0] imm,
                     input logic [31:0] v2, input logic r1, input logic [3:0] q1,
                     input logic [3:0] dest);
    dc_valid = 1'b1; dc_op = op; dc_v1 = v1; dc_imm = imm; dc_v2 = v2;
    dc_rdy1 = r1; dc_q1 = q1; dc_rdy2 = 1'b1; dc_q2 = '0; dc_dest = dest;
    tick();
    dc_valid = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0; rob_head_id = 4'd9;
    dc_valid = 1'b0; dc_op = '0; dc_imm = '0; dc_rdy1 = 1'b1; dc_rdy2 = 1'b1;
    dc_q1 = '0; dc_q2 = '0; dc_v1 = '0; dc_v2 = '0; dc_dest = '0;
    mem_done = 1'b0; mem_rdata = '0; mem_stuck = 1'b0;
    rs_valid = 1'b0; rs_tag = '0; rs_val = '0;

    // Reset state
    #22;
    chk("rst_full", lsb_full, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_f3", mem_funct3, 0);
    chk("rst_outv", out_valid, 0);
    rst_in = 1'b1;
    tick();

    // Speculative load at 0x104
    put(LW, 32'h100, 32'h4, 32'h0, 1'b1, 4'd0, 4'd1);
    chk("lw_no_req_yet", mem_req, 0);
    tick();
    chk("lw_req", mem_req, 1);
    chk("lw_addr", mem_addr, 32'h104);
    chk("lw_we", mem_we, 0);
    chk("lw_f3", mem_funct3, 3'b010);
    mem_done = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_outv", out_valid, 1);
    chk("lw_outtag", out_tag, 1);
    chk("lw_outval", out_val, 32'hDEADBEEF);
    tick();
    mem_done = 1'b0;
    chk("lw_req_drop", mem_req, 0);
    chk("lw_outv_drop", out_valid, 0);

    // Store waits for ROB head
    rob_head_id = 4'd2;
    put(SW, 32'h200, 32'h8, 32'h12345678, 1'b1, 4'd0, 4'd3);
    tick(); tick();
    chk("sw_held", mem_req, 0);
    rob_head_id = 4'd3;
    tick();
    chk("sw_req", mem_req, 1);
    chk("sw_we", mem_we, 1);
    chk("sw_addr", mem_addr, 32'h208);
    chk("sw_wdata", mem_wdata, 32'h12345678);
    mem_done = 1'b1;
    #1;
    chk("sw_outtag", out_tag, 3);
    tick();
    mem_done = 1'b0;

    // MMIO load held until head; just-outside-window load goes speculatively
    put(LW, 32'h30000, 32'h4, 32'h0, 1'b1, 4'd0, 4'd4);
    tick(); tick();
    chk("mmio_held", mem_req, 0);
    rob_head_id = 4'd4;
    tick();
    chk("mmio_req", mem_req, 1);
    chk("mmio_addr", mem_addr, 32'h30004);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    put(LW, 32'h30000, 32'h8, 32'h0, 1'b1, 4'd0, 4'd5);
    tick();
    chk("nonmmio_req", mem_req, 1);
    chk("nonmmio_addr", mem_addr, 32'h30008);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;

    // Wakeup: older entry waits on tag 5; newer entry inserted during broadcast
    put(LW, 32'h0, 32'h0, 32'h0, 1'b0, 4'd5, 4'd6);
    tick();
    chk("wait_no_req", mem_req, 0);
    rs_valid = 1'b1; rs_tag = 4'd5; rs_val = 32'd7;
    put(LW, 32'h0, 32'h10, 32'h0, 1'b0, 4'd5, 4'd7);
    rs_valid = 1'b0;
    tick();
    chk("wake_old_req", mem_req, 1);
    chk("wake_old_addr", mem_addr, 32'h7);
    mem_done = 1'b1;
    #1;
    chk("wake_old_tag", out_tag, 6);
    tick();
    mem_done = 1'b0;
    tick();
    chk("wake_new_req", mem_req, 1);
    chk("wake_new_addr", mem_addr, 32'h17);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;

    // Fill to DEPTH-1 with stores that cannot issue; tail wraps past 15
    rob_head_id = 4'd0;
    for (int i = 0; i < 15; i++) begin
      put(SW, 32'h0, 32'(i * 4), 32'(i), 1'b1, 4'd0, 4'd15);
      if (i == 13) chk("full_at_14", lsb_full, 0);
    end
    chk("full_at_15", lsb_full, 1);
    rob_head_id = 4'd15;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("drain_req", mem_req, 1);
      chk("drain_addr", mem_addr, 32'(i * 4));
      chk("drain_wdata", mem_wdata, 32'(i));
      mem_done = 1'b1;
      if (i == 14) rob_head_id = 4'd0;
      tick();
      mem_done = 1'b0;
      if (i == 0) chk("full_after_pop", lsb_full, 0);
    end
    chk("drain_empty_req", mem_req, 0);

    // Flush while BUSY -> DRAIN, insert during drain, no broadcast
    put(LW, 32'h40, 32'h0, 32'h0, 1'b1, 4'd0, 4'd8);
    tick();
    chk("fl_req", mem_req, 1);
    rob_clear = 1'b1;
    tick();
    rob_clear = 1'b0;
    chk("fl_req_held", mem_req, 1);
    chk("fl_addr_held", mem_addr, 32'h40);
    put(LW, 32'h80, 32'h0, 32'h0, 1'b1, 4'd0, 4'd9);
    chk("fl_no_issue", mem_addr, 32'h40);
    mem_done = 1'b1; mem_rdata = 32'h55;
    #1;
    chk("fl_no_outv", out_valid, 0);
    tick();
    mem_done = 1'b0;
    chk("fl_idle_req", mem_req, 0);
    tick();
    chk("fl_new_req", mem_req, 1);
    chk("fl_new_addr", mem_addr, 32'h80);

    // Asynchronous reset mid-BUSY
    #2 rst_in = 1'b0;
    #1;
    chk("ar_req", mem_req, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_full", lsb_full, 0);
    chk("ar_outv", out_valid, 0);
    #3 rst_in = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
